// File: rtl/frame_pkg.sv
// Shared timing defaults (640x480@60) and width helper for the frame sequencer.
package frame_pkg;

    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BACK   = 48;
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FRONT  = 16;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BACK   = 33;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FRONT  = 10;

    localparam int unsigned DEF_H_TOTAL = DEF_H_SYNC + DEF_H_BACK + DEF_H_ACTIVE + DEF_H_FRONT;
    localparam int unsigned DEF_V_TOTAL = DEF_V_SYNC + DEF_V_BACK + DEF_V_ACTIVE + DEF_V_FRONT;

    // ceil(log2(n)), never below 1 so it is always usable as a vector width
    function automatic int unsigned clog2w(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(n)) r = i + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/vga_timing_core.sv
// Raster h/v counters with registered sync, data-enable, pixel coordinate and frame decode.
module vga_timing_core
    import frame_pkg::*;
#(
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BACK   = DEF_H_BACK,
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FRONT  = DEF_H_FRONT,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BACK   = DEF_V_BACK,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FRONT  = DEF_V_FRONT
) (
    input  logic                          vga_clk,
    input  logic                          sys_rst,
    output logic                          hsync,
    output logic                          vsync,
    output logic                          de,
    output logic [clog2w(H_ACTIVE)-1:0]   pix_x,
    output logic [clog2w(V_ACTIVE)-1:0]   pix_y,
    output logic                          frame,
    output logic                          boundary_c
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int unsigned HW      = clog2w(H_TOTAL);
    localparam int unsigned VW      = clog2w(V_TOTAL);
    localparam int unsigned XW      = clog2w(H_ACTIVE);
    localparam int unsigned YW      = clog2w(V_ACTIVE);
    localparam int unsigned H_ACT0  = H_SYNC + H_BACK;
    localparam int unsigned H_ACT1  = H_ACT0 + H_ACTIVE;
    localparam int unsigned V_ACT0  = V_SYNC + V_BACK;
    localparam int unsigned V_ACT1  = V_ACT0 + V_ACTIVE;

    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic          h_last;
    logic          v_last;
    logic          de_c;
    logic [XW-1:0] x_c;
    logic [YW-1:0] y_c;

    // Region decode done in 32 bits so a zero front porch cannot overflow the compare
    always_comb begin
        h_last     = (32'(h) == H_TOTAL - 1);
        v_last     = (32'(v) == V_TOTAL - 1);
        de_c       = (32'(h) >= H_ACT0) && (32'(h) < H_ACT1) &&
                     (32'(v) >= V_ACT0) && (32'(v) < V_ACT1);
        x_c        = de_c ? XW'(32'(h) - H_ACT0) : '0;
        y_c        = de_c ? YW'(32'(v) - V_ACT0) : '0;
        boundary_c = (h == '0) && (v == '0);
    end

    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            h     <= '0;
            v     <= '0;
            hsync <= 1'b1;
            vsync <= 1'b1;
            de    <= 1'b0;
            pix_x <= '0;
            pix_y <= '0;
            frame <= 1'b0;
        end else begin
            h <= h_last ? '0 : h + HW'(1);
            if (h_last) begin
                v <= v_last ? '0 : v + VW'(1);
            end
            hsync <= (32'(h) >= H_SYNC);
            vsync <= (32'(v) >= V_SYNC);
            de    <= de_c;
            pix_x <= x_c;
            pix_y <= y_c;
            frame <= boundary_c;
        end
    end

endmodule

// File: rtl/frame_seq_gen.sv
// VGA frame generator with a display-mode sequencer that only steps at frame boundaries.
module frame_seq_gen
    import frame_pkg::*;
#(
    parameter int unsigned H_SYNC      = DEF_H_SYNC,
    parameter int unsigned H_BACK      = DEF_H_BACK,
    parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
    parameter int unsigned H_FRONT     = DEF_H_FRONT,
    parameter int unsigned V_SYNC      = DEF_V_SYNC,
    parameter int unsigned V_BACK      = DEF_V_BACK,
    parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
    parameter int unsigned V_FRONT     = DEF_V_FRONT,
    parameter int unsigned N_MODES     = 4,
    parameter int unsigned AUTO_FRAMES = 60,
    parameter int unsigned FCNT_W      = 16
) (
    input  logic                          vga_clk,
    input  logic                          sys_rst,
    input  logic                          key_flag,
    input  logic                          auto_en,
    output logic                          hsync,
    output logic                          vsync,
    output logic                          de,
    output logic [clog2w(H_ACTIVE)-1:0]   pix_x,
    output logic [clog2w(V_ACTIVE)-1:0]   pix_y,
    output logic                          frame,
    output logic [clog2w(N_MODES)-1:0]    mode,
    output logic [FCNT_W-1:0]             frame_cnt
);

    localparam int unsigned MW = clog2w(N_MODES);
    localparam int unsigned AW = clog2w(AUTO_FRAMES);

    logic          boundary_c;
    logic          pending;
    logic [AW-1:0] auto_cnt;
    logic          auto_due;
    logic          step_c;

    vga_timing_core #(
        .H_SYNC   (H_SYNC),
        .H_BACK   (H_BACK),
        .H_ACTIVE (H_ACTIVE),
        .H_FRONT  (H_FRONT),
        .V_SYNC   (V_SYNC),
        .V_BACK   (V_BACK),
        .V_ACTIVE (V_ACTIVE),
        .V_FRONT  (V_FRONT)
    ) u_timing (
        .vga_clk    (vga_clk),
        .sys_rst    (sys_rst),
        .hsync      (hsync),
        .vsync      (vsync),
        .de         (de),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .frame      (frame),
        .boundary_c (boundary_c)
    );

    // A key arriving on the boundary cycle itself is honoured at that boundary
    always_comb begin
        auto_due = auto_en && (32'(auto_cnt) == AUTO_FRAMES - 1);
        step_c   = boundary_c && (pending || key_flag || auto_due);
    end

    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            pending   <= 1'b0;
            auto_cnt  <= '0;
            mode      <= '0;
            frame_cnt <= '0;
        end else begin
            pending <= !boundary_c && (pending || key_flag);
            if (!auto_en) begin
                auto_cnt <= '0;
            end else if (boundary_c) begin
                auto_cnt <= step_c ? '0 : auto_cnt + AW'(1);
            end
            if (step_c) begin
                mode <= (32'(mode) == N_MODES - 1) ? '0 : mode + MW'(1);
            end
            if (boundary_c) begin
                frame_cnt <= frame_cnt + FCNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_frame_seq_gen.sv
// Bench for frame_seq_gen on a 10x6 raster: scoreboard model plus vector table and directed sequences.
module tb_frame_seq_gen;

    localparam int HS = 2, HB = 2, HA = 4, HF = 2;
    localparam int VS = 1, VB = 1, VA = 3, VF = 1;
    localparam int HT = HS + HB + HA + HF;
    localparam int VT = VS + VB + VA + VF;
    localparam int FT = HT * VT;
    localparam int NM = 4, AF = 3, FW = 4;

    logic       vga_clk;
    logic       sys_rst;
    logic       key_flag;
    logic       auto_en;
    logic       hsync;
    logic       vsync;
    logic       de;
    logic [1:0] pix_x;
    logic [1:0] pix_y;
    logic       frame;
    logic [1:0] mode;
    logic [3:0] frame_cnt;

    frame_seq_gen #(
        .H_SYNC (HS), .H_BACK (HB), .H_ACTIVE (HA), .H_FRONT (HF),
        .V_SYNC (VS), .V_BACK (VB), .V_ACTIVE (VA), .V_FRONT (VF),
        .N_MODES (NM), .AUTO_FRAMES (AF), .FCNT_W (FW)
    ) dut (
        .vga_clk   (vga_clk),
        .sys_rst   (sys_rst),
        .key_flag  (key_flag),
        .auto_en   (auto_en),
        .hsync     (hsync),
        .vsync     (vsync),
        .de        (de),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .frame     (frame),
        .mode      (mode),
        .frame_cnt (frame_cnt)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    typedef struct {
        logic hs, vs, de;
        int   px, py;
        logic fr;
        int   md, fc;
    } exp_t;

    typedef struct {
        int   k;
        logic hs, vs, de;
        int   px, py;
        logic fr;
    } vec_t;

    typedef struct {
        bit key;
        int md;
    } fr_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;

    int m_h, m_v, m_auto, m_mode, m_fc;
    bit m_pend;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Reference behaviour: expected registered outputs for the upcoming clock edge
    task automatic model_step(input bit rst, input bit key, input bit aen);
        exp_t e;
        bit   bnd, due, stp;
        if (rst) begin
            m_h = 0; m_v = 0; m_pend = 0; m_auto = 0; m_mode = 0; m_fc = 0;
            e = '{hs: 1'b1, vs: 1'b1, de: 1'b0, px: 0, py: 0, fr: 1'b0, md: 0, fc: 0};
        end else begin
            bnd  = (m_h == 0) && (m_v == 0);
            e.hs = (m_h >= HS);
            e.vs = (m_v >= VS);
            e.de = (m_h >= HS + HB) && (m_h < HS + HB + HA) &&
                   (m_v >= VS + VB) && (m_v < VS + VB + VA);
            e.px = e.de ? m_h - (HS + HB) : 0;
            e.py = e.de ? m_v - (VS + VB) : 0;
            e.fr = bnd;
            due  = aen && (m_auto == AF - 1);
            stp  = bnd && (m_pend || key || due);
            if (bnd) m_fc = (m_fc + 1) % (1 << FW);
            if (stp) m_mode = (m_mode + 1) % NM;
            if (bnd) m_pend = 0;
            else if (key) m_pend = 1;
            if (!aen) m_auto = 0;
            else if (bnd) m_auto = stp ? 0 : m_auto + 1;
            e.md = m_mode;
            e.fc = m_fc;
            m_h++;
            if (m_h == HT) begin
                m_h = 0;
                m_v = (m_v + 1) % VT;
            end
        end
        sbq.push_back(e);
    endtask

    // Drive one cycle at the falling edge, then check the DUT 1 time unit after the rising edge
    task automatic step_cycle(input bit rst, input bit key, input bit aen);
        exp_t e;
        sys_rst  = rst;
        key_flag = key;
        auto_en  = aen;
        model_step(rst, key, aen);
        @(posedge vga_clk);
        #1;
        cyc++;
        e = sbq.pop_front();
        chk("sb_hsync", 32'(hsync), 32'(e.hs));
        chk("sb_vsync", 32'(vsync), 32'(e.vs));
        chk("sb_de", 32'(de), 32'(e.de));
        chk("sb_pix_x", 32'(pix_x), e.px);
        chk("sb_pix_y", 32'(pix_y), e.py);
        chk("sb_frame", 32'(frame), 32'(e.fr));
        chk("sb_mode", 32'(mode), e.md);
        chk("sb_frame_cnt", 32'(frame_cnt), e.fc);
        @(negedge vga_clk);
    endtask

    task automatic run_until_frame(input bit aen, input int budget);
        int n;
        n = 0;
        do begin
            step_cycle(1'b0, 1'b0, aen);
            n++;
        end while (frame !== 1'b1 && n < budget);
        chk("frame_wait", 32'(frame), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_hsync"}, 32'(hsync), 1);
        chk({tag, "_vsync"}, 32'(vsync), 1);
        chk({tag, "_de"}, 32'(de), 0);
        chk({tag, "_pix_x"}, 32'(pix_x), 0);
        chk({tag, "_pix_y"}, 32'(pix_y), 0);
        chk({tag, "_frame"}, 32'(frame), 0);
        chk({tag, "_mode"}, 32'(mode), 0);
        chk({tag, "_frame_cnt"}, 32'(frame_cnt), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vt[10];
        fr_t  ft[15];
        int   hs_low, de_cnt, bad, prev_fc, wrapped;

        vt[0] = '{k: 1,  hs: 0, vs: 0, de: 0, px: 0, py: 0, fr: 1};
        vt[1] = '{k: 2,  hs: 0, vs: 0, de: 0, px: 0, py: 0, fr: 0};
        vt[2] = '{k: 3,  hs: 1, vs: 0, de: 0, px: 0, py: 0, fr: 0};
        vt[3] = '{k: 11, hs: 0, vs: 1, de: 0, px: 0, py: 0, fr: 0};
        vt[4] = '{k: 25, hs: 1, vs: 1, de: 1, px: 0, py: 0, fr: 0};
        vt[5] = '{k: 28, hs: 1, vs: 1, de: 1, px: 3, py: 0, fr: 0};
        vt[6] = '{k: 29, hs: 1, vs: 1, de: 0, px: 0, py: 0, fr: 0};
        vt[7] = '{k: 48, hs: 1, vs: 1, de: 1, px: 3, py: 2, fr: 0};
        vt[8] = '{k: 55, hs: 1, vs: 1, de: 0, px: 0, py: 0, fr: 0};
        vt[9] = '{k: 61, hs: 0, vs: 0, de: 0, px: 0, py: 0, fr: 1};

        ft[0]  = '{key: 0, md: 2};
        ft[1]  = '{key: 0, md: 2};
        ft[2]  = '{key: 0, md: 3};
        ft[3]  = '{key: 0, md: 3};
        ft[4]  = '{key: 0, md: 3};
        ft[5]  = '{key: 0, md: 0};
        ft[6]  = '{key: 0, md: 0};
        ft[7]  = '{key: 0, md: 0};
        ft[8]  = '{key: 0, md: 1};
        ft[9]  = '{key: 0, md: 1};
        ft[10] = '{key: 0, md: 1};
        ft[11] = '{key: 1, md: 2};
        ft[12] = '{key: 0, md: 2};
        ft[13] = '{key: 0, md: 2};
        ft[14] = '{key: 0, md: 3};

        sys_rst  = 1'b1;
        key_flag = 1'b0;
        auto_en  = 1'b0;
        @(negedge vga_clk);
        for (int i = 0; i < 3; i++) step_cycle(1'b1, 1'b0, 1'b0);
        check_reset_outputs("reset");

        // Two frames of raster after release
        hs_low = 0;
        de_cnt = 0;
        for (int k = 1; k <= 2 * FT; k++) begin
            step_cycle(1'b0, 1'b0, 1'b0);
            if (k <= FT) begin
                if (hsync === 1'b0) hs_low++;
                if (de === 1'b1) de_cnt++;
            end
            for (int j = 0; j < 10; j++) begin
                if (vt[j].k == k) begin
                    chk("vec_hsync", 32'(hsync), 32'(vt[j].hs));
                    chk("vec_vsync", 32'(vsync), 32'(vt[j].vs));
                    chk("vec_de", 32'(de), 32'(vt[j].de));
                    chk("vec_pix_x", 32'(pix_x), vt[j].px);
                    chk("vec_pix_y", 32'(pix_y), vt[j].py);
                    chk("vec_frame", 32'(frame), 32'(vt[j].fr));
                end
            end
            if (k == 1) chk("first_frame_cnt", 32'(frame_cnt), 1);
            if (k == FT + 1) chk("second_frame_cnt", 32'(frame_cnt), 2);
        end
        chk("hsync_low_per_frame", hs_low, 12);
        chk("de_per_frame", de_cnt, 12);

        // Three key pulses mid-frame collapse into one step
        for (int i = 0; i < 20; i++) step_cycle(1'b0, 1'b0, 1'b0);
        step_cycle(1'b0, 1'b1, 1'b0);
        step_cycle(1'b0, 1'b0, 1'b0);
        step_cycle(1'b0, 1'b1, 1'b0);
        step_cycle(1'b0, 1'b0, 1'b0);
        step_cycle(1'b0, 1'b1, 1'b0);
        run_until_frame(1'b0, 2 * FT);
        chk("keys_mode", 32'(mode), 1);
        bad = 0;
        for (int i = 0; i < FT - 1; i++) begin
            step_cycle(1'b0, 1'b0, 1'b0);
            if (mode !== 2'd1) bad++;
        end
        chk("mode_stable_in_frame", bad, 0);

        // Key on the exact boundary cycle steps at that boundary
        step_cycle(1'b0, 1'b1, 1'b0);
        chk("edge_key_frame", 32'(frame), 1);
        chk("edge_key_mode", 32'(mode), 2);

        // Automatic stepping every AF frames, one key merged with an auto-due boundary
        for (int f = 0; f < 15; f++) begin
            for (int i = 1; i <= FT; i++) step_cycle(1'b0, ft[f].key && (i == 20), 1'b1);
            chk("auto_frame", 32'(frame), 1);
            chk("auto_mode", 32'(mode), ft[f].md);
        end

        // Reset mid-frame with a key pending
        for (int i = 0; i < 25; i++) step_cycle(1'b0, i == 5, 1'b0);
        step_cycle(1'b1, 1'b0, 1'b0);
        check_reset_outputs("midreset");
        step_cycle(1'b0, 1'b0, 1'b0);
        chk("post_rst_frame", 32'(frame), 1);
        chk("post_rst_mode", 32'(mode), 0);
        chk("post_rst_frame_cnt", 32'(frame_cnt), 1);
        for (int i = 0; i < FT; i++) step_cycle(1'b0, 1'b0, 1'b0);
        chk("post_rst_next_frame", 32'(frame), 1);
        chk("post_rst_next_mode", 32'(mode), 0);

        // Frame counter wraps 15 -> 0
        prev_fc = int'(frame_cnt);
        wrapped = 0;
        for (int f = 0; f < (1 << FW) + 1; f++) begin
            for (int i = 0; i < FT; i++) step_cycle(1'b0, 1'b0, 1'b0);
            if (prev_fc == 15 && frame_cnt === 4'd0) wrapped = 1;
            prev_fc = int'(frame_cnt);
        end
        chk("frame_cnt_wrapped", wrapped, 1);
        chk("frame_cnt_final", 32'(frame_cnt), 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
